// File: rtl/pattern_detect_ctrl.sv
// Programmable serial pattern detector with IDLE/RUN/DONE control and hit counting.
// y registers on the edge accepting the completing bit; no backpressure. NON_OVERLAP_EN restarts fill after each hit.
module pattern_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic [CNT_W-1:0]               cfg_target,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           din,
  input  logic                           din_valid,
  output logic                           y,
  output logic [CNT_W-1:0]               hit_count,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err
);

  localparam int LEN_W = $clog2(MAX_LEN+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_target;
  logic [MAX_LEN-1:0] r_shift;
  logic [LEN_W-1:0]   r_fill;
  logic               r_y;
  logic [CNT_W-1:0]   r_hit;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_err;

  logic [MAX_LEN-1:0] w_shift_nxt;
  logic [LEN_W-1:0]   w_fill_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;
  logic [CNT_W-1:0]   w_hit_nxt;
  logic               w_cfg_ok;

  assign y         = r_y;
  assign hit_count = r_hit;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;

  // Match is judged on the value the shift register takes on this edge.
  always_comb begin
    w_shift_nxt = {r_shift[MAX_LEN-2:0], din};
    w_fill_nxt  = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
    w_mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
    w_match   = (w_fill_nxt >= r_len) && (((w_shift_nxt ^ r_pattern) & w_mask) == '0);
    w_hit_nxt = (&r_hit) ? r_hit : r_hit + 1'b1;
    w_cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pattern <= MAX_LEN'(6'b001001);
      r_len     <= LEN_W'(6);
      r_target  <= '0;
      r_shift   <= '0;
      r_fill    <= '0;
      r_y       <= 1'b0;
      r_hit     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_y     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_y <= 1'b0;
          if (cfg_load) begin
            if (w_cfg_ok) begin
              r_pattern <= cfg_pattern;
              r_len     <= cfg_len;
              r_target  <= cfg_target;
              r_cfg_err <= 1'b0;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
          if (start) begin
            r_state <= S_RUN;
            r_hit   <= '0;
            r_shift <= '0;
            r_fill  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_y <= 1'b0;
          if (din_valid) begin
            r_shift <= w_shift_nxt;
            r_fill  <= w_fill_nxt;
            if (w_match) begin
              r_y   <= 1'b1;
              r_hit <= w_hit_nxt;
`ifdef NON_OVERLAP_EN
              r_fill <= '0;
`else
              r_fill <= w_fill_nxt;
`endif
              if ((r_target != '0) && (w_hit_nxt == r_target)) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_y <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_hit   <= '0;
            r_shift <= '0;
            r_fill  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Bench for pattern_detect_ctrl: vector table, hand-written corner sequences, random run against a bit-history model.
module tb_pattern_detect_ctrl;

`ifdef NON_OVERLAP_EN
  localparam bit NOV = 1'b1;
`else
  localparam bit NOV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, cfg_load, start, abort, din, din_valid;
  logic [7:0] cfg_pattern, cfg_target;
  logic [3:0] cfg_len;
  logic       y, busy, done, cfg_err;
  logic [7:0] hit_count;

  pattern_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_target(cfg_target), .start(start), .abort(abort),
    .din(din), .din_valid(din_valid), .y(y), .hit_count(hit_count),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: mode 0=idle 1=run 2=done; matching looks at the raw history of accepted bits.
  int         m_mode, m_len, m_tgt, m_hits, m_since;
  logic [7:0] m_pat;
  bit         m_y, m_err;
  bit         m_hist[$];

  task automatic m_reset();
    m_mode = 0; m_pat = 8'h09; m_len = 6; m_tgt = 0; m_hits = 0;
    m_y = 1'b0; m_err = 1'b0; m_since = 0; m_hist.delete();
  endtask

  task automatic m_begin();
    m_mode = 1; m_hits = 0; m_since = 0; m_hist.delete();
  endtask

  task automatic m_step(input bit st, ab, ld, d, v, input logic [7:0] pat, input int len, input int tgt);
    bit ok;
    m_y = 1'b0;
    if (ab) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (ld) begin
        if (len >= 1 && len <= 8) begin
          m_pat = pat; m_len = len; m_tgt = tgt; m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (st) m_begin();
    end else if (m_mode == 1) begin
      if (v) begin
        m_hist.push_back(d);
        if (m_hist.size() > 16) void'(m_hist.pop_front());
        m_since++;
        ok = (m_since >= m_len);
        for (int k = 0; k < m_len && ok; k++)
          if (m_hist[m_hist.size()-1-k] != m_pat[k]) ok = 1'b0;
        if (ok) begin
          m_y = 1'b1;
          if (m_hits < 255) m_hits++;
          if (NOV) m_since = 0;
          if (m_tgt != 0 && m_hits == m_tgt) m_mode = 2;
        end
      end
    end else begin
      if (st) m_begin();
    end
  endtask

  task automatic cyc(input bit st, ab, ld, d, v, input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt);
    start = st; abort = ab; cfg_load = ld; din = d; din_valid = v;
    cfg_pattern = pat; cfg_len = len; cfg_target = tgt;
    @(posedge clk);
    m_step(st, ab, ld, d, v, pat, int'(len), int'(tgt));
    #1;
  endtask

  task automatic bitc(input bit d, input bit v);
    cyc(1'b0, 1'b0, 1'b0, d, v, 8'h00, 4'd0, 8'd0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_exp(input string tag, input bit ey, input int eh, input bit eb, input bit ed, input bit ee);
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".hit_count"}, 32'(hit_count), eh);
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".cfg_err"}, 32'(cfg_err), 32'(ee));
  endtask

  task automatic chk_model(input string tag);
    chk_exp(tag, m_y, m_hits, (m_mode == 1), (m_mode == 2), m_err);
  endtask

  typedef struct {
    bit st, ab, ld, d, v;
    logic [7:0] pat;
    logic [3:0] len;
    logic [7:0] tgt;
    bit ey;
    int eh;
    bit eb, ed, ee;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input bit st, ab, ld, d, v, input int pat, len, tgt,
                              input bit ey, input int eh, input bit eb, ed, ee);
    vec_t r;
    r.st = st; r.ab = ab; r.ld = ld; r.d = d; r.v = v;
    r.pat = pat[7:0]; r.len = len[3:0]; r.tgt = tgt[7:0];
    r.ey = ey; r.eh = eh; r.eb = eb; r.ed = ed; r.ee = ee;
    return r;
  endfunction

  initial begin
    logic [11:0] sa;
    logic [8:0]  bdat, bval;
    int          p2, h2, rl;
    bit          rst_, rab, rld, rd, rv;

    reset = 1'b1; cfg_load = 0; start = 0; abort = 0; din = 0; din_valid = 0;
    cfg_pattern = 0; cfg_len = 0; cfg_target = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_exp("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    h2 = NOV ? 1 : 2;
    //            st ab ld d  v  pat    len tgt   y           hit eb ed ee
    tbl[0]  = mk(1, 0, 0, 0, 0, 'h00, 0, 0,    0,          0,  1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 'h00, 0, 0,    0,          0,  1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 'h00, 0, 0,    0,          0,  1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 'h00, 0, 0,    0,          0,  1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 1, 'h00, 0, 0,    0,          0,  1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1, 'h00, 0, 0,    0,          0,  1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 1, 1, 'h00, 0, 0,    1,          1,  1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 'h00, 0, 0,    0,          1,  1, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 'h00, 0, 0,    0,          1,  0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 'h05, 3, 0,    0,          1,  0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 'h00, 0, 0,    0,          0,  1, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 1, 'h00, 0, 0,    0,          0,  1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 'h00, 0, 0,    0,          0,  1, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 1, 'h00, 0, 0,    1,          1,  1, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 1, 'h00, 0, 0,    0,          1,  1, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 1, 'h00, 0, 0,    !NOV,       h2, 1, 0, 0);
    tbl[16] = mk(0, 1, 0, 0, 0, 'h00, 0, 0,    0,          h2, 0, 0, 0);
    tbl[17] = mk(0, 0, 1, 0, 0, 'hFF, 0, 0,    0,          h2, 0, 0, 1);
    tbl[18] = mk(0, 0, 1, 0, 0, 'hFF, 9, 0,    0,          h2, 0, 0, 1);
    tbl[19] = mk(1, 0, 0, 0, 0, 'h00, 0, 0,    0,          0,  1, 0, 1);
    tbl[20] = mk(0, 0, 0, 1, 1, 'h00, 0, 0,    0,          0,  1, 0, 1);
    tbl[21] = mk(0, 0, 0, 0, 1, 'h00, 0, 0,    0,          0,  1, 0, 1);
    tbl[22] = mk(0, 0, 0, 1, 1, 'h00, 0, 0,    1,          1,  1, 0, 1);
    tbl[23] = mk(0, 0, 1, 0, 0, 'h09, 6, 1,    0,          1,  1, 0, 1);
    tbl[24] = mk(0, 0, 0, 0, 1, 'h00, 0, 0,    0,          1,  1, 0, 1);
    tbl[25] = mk(0, 0, 0, 1, 1, 'h00, 0, 0,    !NOV,       h2, 1, 0, 1);
    tbl[26] = mk(1, 1, 0, 0, 0, 'h00, 0, 0,    0,          h2, 0, 0, 1);
    tbl[27] = mk(0, 0, 1, 0, 0, 'h09, 6, 2,    0,          h2, 0, 0, 0);

    for (int i = 0; i < 28; i++) begin
      cyc(tbl[i].st, tbl[i].ab, tbl[i].ld, tbl[i].d, tbl[i].v, tbl[i].pat, tbl[i].len, tbl[i].tgt);
      chk_exp($sformatf("vec%0d", i), tbl[i].ey, tbl[i].eh, tbl[i].eb, tbl[i].ed, tbl[i].ee);
    end

    // Target of 2 on 001001001001: DONE freezes the counter and swallows the tail.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'd0);
    chk_exp("tgt_start", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    sa = 12'b001001001001;
    p2 = NOV ? 12 : 9;
    for (int i = 1; i <= 12; i++) begin
      bitc(sa[12-i], 1'b1);
      chk_exp($sformatf("tgt_bit%0d", i), (i == 6 || i == p2),
              (i >= p2) ? 2 : ((i >= 6) ? 1 : 0), (i < p2), (i >= p2), 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'd0);
    chk_exp("tgt_restart", 1'b0, 0, 1'b1, 1'b0, 1'b0);

    // Invalid cycles with din=1 inside the pattern must not disturb the history.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h09, 4'd6, 8'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'd0);
    chk_exp("gap_start", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    bdat = 9'b001111001;
    bval = 9'b111000111;
    for (int i = 0; i < 9; i++) begin
      bitc(bdat[8-i], bval[8-i]);
      chk($sformatf("gap%0d.y", i), 32'(y), 32'(i == 8));
      chk($sformatf("gap%0d.hit_count", i), 32'(hit_count), 32'(i == 8));
    end

    // Asynchronous reset between edges while running.
    chk("pre_arst.busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk_exp("arst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    m_reset();

    for (int n = 0; n < 3000; n++) begin
      rst_ = ($urandom_range(0, 19) == 0);
      rab  = ($urandom_range(0, 49) == 0);
      rld  = ($urandom_range(0, 14) == 0);
      rd   = 1'($urandom_range(0, 1));
      rv   = ($urandom_range(0, 3) != 0);
      rl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
      cyc(rst_, rab, rld, rd, rv, 8'($urandom_range(0, 255)), 4'(rl), 8'($urandom_range(0, 4)));
      chk_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_detect_ctrl.md
Name: pattern_detect_ctrl

Overview:
Programmable serial pattern-detection controller for the team's Moore sequence detectors. It holds a loadable pattern and length and gates a qualified serial bit stream through a detection window. It counts hits against a programmable target and runs an IDLE/RUN/DONE control FSM. Sits between the serial source and downstream logic that consumes the one-cycle hit flag y and the completion status.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of hit counter and target

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
cfg_load  input  1  load cfg_pattern/cfg_len/cfg_target (accepted in IDLE only)
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is first bit received, bit [0] is last
cfg_len  input  $clog2(MAX_LEN+1)  pattern length, legal 1..MAX_LEN
cfg_target  input  CNT_W  hits until DONE; 0 means run forever
start  input  1  begin/restart detection (IDLE or DONE)
abort  input  1  return to IDLE
din  input  1  serial data bit
din_valid  input  1  din qualifier
y  output  1  registered hit flag, one-cycle pulse
hit_count  output  CNT_W  hits since last start
busy  output  1  high in RUN
done  output  1  high in DONE
cfg_err  output  1  sticky illegal-config flag

Behaviour:
- Clock is clk; reset is asynchronous and active-high.
- Reset (async, immediate): FSM=IDLE; y=0, hit_count=0, busy=0, done=0, cfg_err=0; shift register and fill counter cleared; pattern=001001 (zero-extended), len=6, target=0.
- IDLE: cfg_load with cfg_len in 1..MAX_LEN latches all three cfg fields on that edge and clears cfg_err. cfg_load with cfg_len=0 or >MAX_LEN leaves the config unchanged and sets cfg_err. start -> RUN; clears hit_count, shift register and fill.
- RUN: busy=1. On each edge with din_valid=1: shift <= {shift[MAX_LEN-2:0], din}; fill increments, saturating at MAX_LEN. Edges with din_valid=0 change nothing.
- Match condition: evaluated on the post-shift value: fill >= len and shift[len-1:0] == pattern[len-1:0].
- Match result: y=1 for exactly one cycle, registered on the same edge that accepts the completing bit. Zero-cycle latency from that edge, Moore-style (y is purely a register). hit_count increments on the same edge and saturates at all-ones.
- Overlap: overlapping matches allowed; fill is not cleared on a match.
- RUN -> DONE: on the edge where hit_count becomes cfg_target (target != 0). The bit that completes the target hit still produces y.
- DONE: done=1, busy=0, y=0. Bits are ignored and hit_count is held. start -> RUN with the same clears as from IDLE.
- abort in any state -> IDLE next edge. y=0, busy=0, done=0; hit_count and config retained.
- abort and start together: abort wins. start in RUN is ignored. cfg_load outside IDLE is ignored (no cfg_err).
- Async reset during RUN: all outputs low immediately and config returns to defaults.

Optional Feature:
NON_OVERLAP_EN: when defined, fill is cleared on every match, so the next hit needs len fresh valid bits. When undefined, overlapping detection applies as specified in Behaviour.

Test Plan:
- Reset, start, default config, stream 0,0,1,0,0,1 (valid every cycle) -> y=1 only in the cycle after the 6th bit's edge; hit_count=1; busy=1.
- Load pattern=101, len=3, target=0; start; stream 1,0,1,0,1 -> two y pulses (after bits 3 and 5), hit_count=2. With NON_OVERLAP_EN -> one pulse, hit_count=1.
- Default config, target=2; stream 001001001001 -> pulses after bits 6 and 9; done=1 after bit 9; bit 12 gives no pulse; hit_count stays 2. Then start -> RUN with hit_count=0.
- Default config; stream 0,0,1 then 3 cycles with din_valid=0 and din=1, then 0,0,1 -> exactly one hit, after the final bit.
- In IDLE, cfg_load with cfg_len=0 -> cfg_err=1 and config unchanged (001001 still detected). cfg_load during RUN -> ignored, cfg_err unchanged.
- Mid-stream abort with start on the same cycle -> IDLE, hit_count retained. Async reset asserted between clock edges during RUN -> y/busy/done/hit_count go to 0 without waiting for a clock edge.
